// File: rtl/my_nios1_onchip_memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// my_nios1_onchip_memory_arbiter_if
//
// Purpose:
//   Bundles the bus signals of the two-requester on-chip RAM arbiter: the two
//   Avalon-MM requester ports (m0_*, m1_*) and the single-port RAM side
//   (mem_*). Clock and reset are not part of the bundle.
//
// Modports:
//   slave  - the arbiter's view: requester commands and RAM read data are
//            inputs; waitrequest/readdata/readdatavalid and all RAM
//            controls are outputs.
//   master - the surrounding system's view (requesters plus RAM), the
//            exact mirror of slave.
//
// Signals (N = 0,1):
//   mN_address       ADDR_W  requester N word address
//   mN_byteenable    BE_W    requester N byte enables
//   mN_read          1       requester N read request
//   mN_write         1       requester N write request
//   mN_writedata     DATA_W  requester N write data
//   mN_lock          1       requester N asks to keep the grant
//   mN_waitrequest   1       request from N not accepted this cycle
//   mN_readdata      DATA_W  read data (RAM read data broadcast)
//   mN_readdatavalid 1       mN_readdata valid for N's accepted read
//   mem_address      ADDR_W  RAM word address
//   mem_byteenable   BE_W    RAM byte enables
//   mem_chipselect   1       RAM select
//   mem_write        1       RAM write (qualified by chipselect)
//   mem_writedata    DATA_W  RAM write data
//   mem_clken        1       RAM clock enable
//   mem_readdata     DATA_W  RAM read data, one cycle after a read
// ---------------------------------------------------------------------------
interface my_nios1_onchip_memory_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
);
    // Requester 0
    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_lock;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    // Requester 1
    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_lock;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    // RAM side
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/my_nios1_onchip_memory_arbiter.sv
// ---------------------------------------------------------------------------
// my_nios1_onchip_memory_arbiter
//
// Purpose:
//   Shares one single-port on-chip RAM (1-cycle read latency) between two
//   Avalon-MM requesters, typically the Nios data master and a DMA.
//   Round-robin arbitration with an optional bounded lock. The grant is
//   combinational, so an uncontended access reaches the RAM in the same
//   cycle and sees no extra latency.
//
// Parameters:
//   ADDR_W   word address width
//   DATA_W   data width
//   BE_W     byte-enable width (DATA_W/8)
//   MAX_HOLD max consecutive granted cycles a locking owner may keep the
//            RAM while the other requester waits (>= 1)
//
// Ports:
//   clk    in  clock
//   reset  in  asynchronous reset, active-high
//   bus    slave modport of my_nios1_onchip_memory_arbiter_if carrying both
//          requester ports and the RAM port
// ---------------------------------------------------------------------------
module my_nios1_onchip_memory_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int BE_W     = DATA_W / 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    my_nios1_onchip_memory_arbiter_if.slave    bus
);

    // Owner FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Hold counter wide enough to hold MAX_HOLD itself
    localparam int              HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic              r_last;        // id granted most recently
    logic [HOLD_W-1:0] r_hold_cnt;    // consecutive cycles of the current owner
    logic              r_rd_pend;     // a read was accepted last cycle
    logic              r_rd_owner;    // which requester that read belongs to

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic              w_req0;
    logic              w_req1;
    logic              w_keep0;       // owner 0 may keep the RAM under lock
    logic              w_keep1;       // owner 1 may keep the RAM under lock
    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic [1:0]        w_gnt_state;   // owner state matching the current grant
    logic [1:0]        w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;

    logic [ADDR_W-1:0] w_sel_address;
    logic [BE_W-1:0]   w_sel_byteenable;
    logic [DATA_W-1:0] w_sel_writedata;
    logic              w_sel_read;
    logic              w_sel_write;
    logic              w_acc_write;
    logic              w_acc_read;

    // A port asserting read and write together is treated as a write, so
    // either strobe alone is enough to count as a request.
    assign w_req0 = bus.m0_read | bus.m0_write;
    assign w_req1 = bus.m1_read | bus.m1_write;

    // A locking owner keeps the RAM only while its run is below MAX_HOLD;
    // once it saturates, round-robin hands the RAM to the other side.
    assign w_keep0 = (r_state == ST_OWN0) & bus.m0_lock & (r_hold_cnt < HOLD_MAX);
    assign w_keep1 = (r_state == ST_OWN1) & bus.m1_lock & (r_hold_cnt < HOLD_MAX);

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = 1'b0;
        if (!reset) begin
            if (w_req0 && !w_req1) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = 1'b0;
            end else if (w_req1 && !w_req0) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = 1'b1;
            end else if (w_req0 && w_req1) begin
                w_gnt_valid = 1'b1;
                if (w_keep0) begin
                    w_gnt_id = 1'b0;
                end else if (w_keep1) begin
                    w_gnt_id = 1'b1;
                end else begin
                    w_gnt_id = ~r_last;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Granted-port selection and access qualification
    // ------------------------------------------------------------------
    always_comb begin
        if (w_gnt_id) begin
            w_sel_address    = bus.m1_address;
            w_sel_byteenable = bus.m1_byteenable;
            w_sel_writedata  = bus.m1_writedata;
            w_sel_read       = bus.m1_read;
            w_sel_write      = bus.m1_write;
        end else begin
            w_sel_address    = bus.m0_address;
            w_sel_byteenable = bus.m0_byteenable;
            w_sel_writedata  = bus.m0_writedata;
            w_sel_read       = bus.m0_read;
            w_sel_write      = bus.m0_write;
        end
    end

    // Write wins when both strobes are up on the granted port.
    assign w_acc_write = w_gnt_valid & w_sel_write;
    assign w_acc_read  = w_gnt_valid & w_sel_read & ~w_sel_write;

    // ------------------------------------------------------------------
    // Next owner state and hold count
    // ------------------------------------------------------------------
    assign w_gnt_state = w_gnt_id ? ST_OWN1 : ST_OWN0;

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
        if (w_gnt_valid) begin
            w_state_nxt = w_gnt_state;
            if (r_state == w_gnt_state) begin
                // Same owner again: extend the run, saturating at MAX_HOLD.
                w_hold_nxt = (r_hold_cnt == HOLD_MAX) ? HOLD_MAX : r_hold_cnt + HOLD_ONE;
            end else begin
                // Switch of owner or first grant out of IDLE.
                w_hold_nxt = HOLD_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;     // m0 wins the first tie after reset
            r_hold_cnt <= '0;
            r_rd_pend  <= 1'b0;     // an in-flight read is dropped by reset
            r_rd_owner <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            if (w_gnt_valid) begin
                r_last <= w_gnt_id;
            end
            r_rd_pend <= w_acc_read;
            if (w_acc_read) begin
                r_rd_owner <= w_gnt_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM side
    // ------------------------------------------------------------------
    assign bus.mem_address    = w_sel_address;
    assign bus.mem_byteenable = w_sel_byteenable;
    assign bus.mem_writedata  = w_sel_writedata;
    assign bus.mem_chipselect = w_gnt_valid;
    assign bus.mem_write      = w_acc_write;
    assign bus.mem_clken      = ~reset;

    // ------------------------------------------------------------------
    // Requester side
    // ------------------------------------------------------------------
    // Stall only a port that is requesting but not granted; an idle port
    // sees waitrequest low. Both ports are stalled while reset is high.
    assign bus.m0_waitrequest = reset | (w_req0 & ~(w_gnt_valid & ~w_gnt_id));
    assign bus.m1_waitrequest = reset | (w_req1 & ~(w_gnt_valid &  w_gnt_id));

    // RAM data is broadcast; only the owner of last cycle's read sees valid.
    assign bus.m0_readdata      = bus.mem_readdata;
    assign bus.m1_readdata      = bus.mem_readdata;
    assign bus.m0_readdatavalid = ~reset & r_rd_pend & ~r_rd_owner;
    assign bus.m1_readdatavalid = ~reset & r_rd_pend &  r_rd_owner;

endmodule

// File: tb/tb_my_nios1_onchip_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_my_nios1_onchip_memory_arbiter
//
// Self-checking bench for the two-requester on-chip RAM arbiter. Contains a
// behavioural RAM (1-cycle read latency, byte enables), a table of directed
// vectors, hand-written lock / byte-write / reset sequences and a randomized
// phase checked against a reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_my_nios1_onchip_memory_arbiter;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int MAX_HOLD = 8;
    localparam int RAM_WORDS = 1 << ADDR_W;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    my_nios1_onchip_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

    my_nios1_onchip_memory_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural RAM
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ram [0:RAM_WORDS-1];

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h010) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h0001_0003) ^ 32'h5A00_0000;
    endfunction

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) ram[i] <= init_word(i);
    end

    always @(posedge clk) begin
        if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (bus.mem_byteenable[b])
                        ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
            end else begin
                bus.mem_readdata <= ram[bus.mem_address];
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_m0(input logic rd, input logic wr, input logic lk,
                          input logic [12:0] a, input logic [3:0] be, input logic [31:0] wd);
        bus.m0_read = rd; bus.m0_write = wr; bus.m0_lock = lk;
        bus.m0_address = a; bus.m0_byteenable = be; bus.m0_writedata = wd;
    endtask

    task automatic set_m1(input logic rd, input logic wr, input logic lk,
                          input logic [12:0] a, input logic [3:0] be, input logic [31:0] wd);
        bus.m1_read = rd; bus.m1_write = wr; bus.m1_lock = lk;
        bus.m1_address = a; bus.m1_byteenable = be; bus.m1_writedata = wd;
    endtask

    task automatic idle_all();
        set_m0(0, 0, 0, '0, 4'hF, '0);
        set_m1(0, 0, 0, '0, 4'hF, '0);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_rst_wait0"}, bus.m0_waitrequest, 1);
        check({tag, "_rst_wait1"}, bus.m1_waitrequest, 1);
        check({tag, "_rst_rdv0"},  bus.m0_readdatavalid, 0);
        check({tag, "_rst_rdv1"},  bus.m1_readdatavalid, 0);
        check({tag, "_rst_cs"},    bus.mem_chipselect, 0);
        check({tag, "_rst_mw"},    bus.mem_write, 0);
        check({tag, "_rst_clken"}, bus.mem_clken, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        rd0, wr0, lk0;
        logic [12:0] a0;
        logic [31:0] wd0;
        logic        rd1, wr1, lk1;
        logic [12:0] a1;
        logic [31:0] wd1;
        logic        exp_wait0, exp_wait1, exp_cs, exp_mw, exp_rdv0, exp_rdv1;
        logic [12:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    // ------------------------------------------------------------------
    // Reference model state for the randomized phase
    // ------------------------------------------------------------------
    logic [31:0] shadow [0:RAM_WORDS-1];
    int          mdl_owner;   // requester that had the RAM last cycle, -1 if none
    int          mdl_streak;  // length of that requester's current run, capped
    int          mdl_last;    // most recent requester to get the RAM
    bit          mdl_pend;
    int          mdl_pend_id;
    logic [31:0] mdl_pend_data;

    initial begin
        reset = 1'b0;
        idle_all();
        bus.mem_readdata = '0;

        // Stimulus table, applied back to back straight after reset.
        //            rd0 wr0 lk0 a0      wd0           rd1 wr1 lk1 a1      wd1           w0 w1 cs mw v0 v1 addr    rdata
        vecs[0]  = '{0, 1, 0, 13'h020, 32'h1111_1111, 0, 1, 0, 13'h021, 32'h2222_2222, 0, 1, 1, 1, 0, 0, 13'h020, 32'h0};
        vecs[1]  = '{0, 1, 0, 13'h020, 32'h1111_1111, 0, 1, 0, 13'h021, 32'h2222_2222, 1, 0, 1, 1, 0, 0, 13'h021, 32'h0};
        vecs[2]  = '{0, 1, 0, 13'h020, 32'h1111_1111, 0, 1, 0, 13'h021, 32'h2222_2222, 0, 1, 1, 1, 0, 0, 13'h020, 32'h0};
        vecs[3]  = '{0, 1, 0, 13'h020, 32'h1111_1111, 0, 1, 0, 13'h021, 32'h2222_2222, 1, 0, 1, 1, 0, 0, 13'h021, 32'h0};
        vecs[4]  = '{0, 0, 0, 13'h000, 32'h0,         0, 0, 0, 13'h000, 32'h0,         0, 0, 0, 0, 0, 0, 13'h000, 32'h0};
        vecs[5]  = '{1, 0, 0, 13'h010, 32'h0,         0, 0, 0, 13'h000, 32'h0,         0, 0, 1, 0, 0, 0, 13'h010, 32'h0};
        vecs[6]  = '{0, 0, 0, 13'h000, 32'h0,         0, 0, 0, 13'h000, 32'h0,         0, 0, 0, 0, 1, 0, 13'h000, 32'hDEAD_BEEF};
        vecs[7]  = '{0, 0, 0, 13'h000, 32'h0,         1, 0, 0, 13'h021, 32'h0,         0, 0, 1, 0, 0, 0, 13'h021, 32'h0};
        vecs[8]  = '{0, 0, 0, 13'h000, 32'h0,         0, 0, 0, 13'h000, 32'h0,         0, 0, 0, 0, 0, 1, 13'h000, 32'h2222_2222};
        vecs[9]  = '{1, 1, 0, 13'h022, 32'h3333_3333, 0, 0, 0, 13'h000, 32'h0,         0, 0, 1, 1, 0, 0, 13'h022, 32'h0};
        vecs[10] = '{0, 0, 0, 13'h000, 32'h0,         0, 0, 0, 13'h000, 32'h0,         0, 0, 0, 0, 0, 0, 13'h000, 32'h0};

        step();
        apply_reset("init");

        // ---------------- Table-driven vectors ----------------
        for (int v = 0; v < NVEC; v++) begin
            set_m0(vecs[v].rd0, vecs[v].wr0, vecs[v].lk0, vecs[v].a0, 4'hF, vecs[v].wd0);
            set_m1(vecs[v].rd1, vecs[v].wr1, vecs[v].lk1, vecs[v].a1, 4'hF, vecs[v].wd1);
            @(negedge clk);
            check($sformatf("vec%0d_wait0", v), bus.m0_waitrequest, vecs[v].exp_wait0);
            check($sformatf("vec%0d_wait1", v), bus.m1_waitrequest, vecs[v].exp_wait1);
            check($sformatf("vec%0d_cs", v),    bus.mem_chipselect, vecs[v].exp_cs);
            check($sformatf("vec%0d_mw", v),    bus.mem_write, vecs[v].exp_mw);
            check($sformatf("vec%0d_rdv0", v),  bus.m0_readdatavalid, vecs[v].exp_rdv0);
            check($sformatf("vec%0d_rdv1", v),  bus.m1_readdatavalid, vecs[v].exp_rdv1);
            if (vecs[v].exp_cs)
                check($sformatf("vec%0d_addr", v), bus.mem_address, vecs[v].exp_addr);
            if (vecs[v].exp_rdv0)
                check($sformatf("vec%0d_rdata0", v), bus.m0_readdata, vecs[v].exp_rdata);
            if (vecs[v].exp_rdv1)
                check($sformatf("vec%0d_rdata1", v), bus.m1_readdata, vecs[v].exp_rdata);
            step();
        end
        idle_all();
        step();

        // ---------------- Bounded lock ----------------
        // m1 reads continuously with lock; m0 joins one cycle later.
        // Expected: m1 for 8 cycles, m0 once, then m1 for 8 more (run restarts at 1).
        for (int k = 0; k < 18; k++) begin
            set_m1(1, 0, 1, 13'h030, 4'hF, '0);
            if (k >= 1) set_m0(1, 0, 0, 13'h031, 4'hF, '0);
            @(negedge clk);
            check($sformatf("lock%0d_wait1", k), bus.m1_waitrequest, ((k % 9) == 8) ? 1 : 0);
            if (k >= 1)
                check($sformatf("lock%0d_wait0", k), bus.m0_waitrequest, ((k % 9) == 8) ? 0 : 1);
            step();
        end
        idle_all();
        step();

        // ---------------- Byte-enabled write then read ----------------
        set_m0(0, 1, 0, 13'h005, 4'b0001, 32'h0000_00AA);
        @(negedge clk);
        check("bw_wait0", bus.m0_waitrequest, 0);
        check("bw_be", bus.mem_byteenable, 4'b0001);
        step();
        idle_all();
        set_m1(1, 0, 0, 13'h005, 4'hF, '0);
        @(negedge clk);
        check("bw_rd_wait1", bus.m1_waitrequest, 0);
        step();
        idle_all();
        @(negedge clk);
        check("bw_rdv1", bus.m1_readdatavalid, 1);
        check("bw_rdv0", bus.m0_readdatavalid, 0);
        begin
            logic [31:0] orig;
            orig = init_word(5);
            check("bw_rdata", bus.m1_readdata, {orig[31:8], 8'hAA});
        end
        step();

        // ---------------- Reset while a read is in flight ----------------
        set_m1(1, 0, 0, 13'h010, 4'hF, '0);
        step();                              // m1 read accepted on this edge
        idle_all();
        set_m0(0, 1, 0, 13'h040, 4'hF, 32'hFFFF_FFFF);  // must not reach the RAM
        apply_reset("midrd");
        idle_all();
        @(negedge clk);
        check("midrd_rdv1_after", bus.m1_readdatavalid, 0);
        check("midrd_rdv0_after", bus.m0_readdatavalid, 0);
        step();
        set_m0(1, 0, 0, 13'h010, 4'hF, '0);
        set_m1(1, 0, 0, 13'h011, 4'hF, '0);
        @(negedge clk);
        check("midrd_tie_wait0", bus.m0_waitrequest, 0);
        check("midrd_tie_wait1", bus.m1_waitrequest, 1);
        check("midrd_tie_addr", bus.mem_address, 13'h010);
        step();
        idle_all();
        @(negedge clk);
        check("midrd_tie_rdv0", bus.m0_readdatavalid, 1);
        check("midrd_tie_rdata", bus.m0_readdata, 32'hDEAD_BEEF);
        check("midrd_ram_kept", ram[13'h040], init_word(13'h040));
        step();

        // ---------------- Randomized phase against the reference model ----------------
        idle_all();
        apply_reset("rnd");
        for (int i = 0; i < RAM_WORDS; i++) shadow[i] = ram[i];
        mdl_owner  = -1;
        mdl_streak = 0;
        mdl_last   = 1;
        mdl_pend   = 0;
        mdl_pend_id = 0;
        mdl_pend_data = '0;

        for (int c = 0; c < 600; c++) begin
            logic        rd [2];
            logic        wr [2];
            logic        lk [2];
            logic [12:0] ad [2];
            logic [3:0]  be [2];
            logic [31:0] wd [2];
            bit          rq [2];
            int          g;

            for (int n = 0; n < 2; n++) begin
                int op;
                op    = $urandom_range(0, 7);          // mostly busy, occasionally both strobes
                rd[n] = (op == 1) || (op == 2) || (op == 3) || (op == 7);
                wr[n] = (op == 4) || (op == 5) || (op == 7);
                lk[n] = 1'($urandom_range(0, 1));
                ad[n] = 13'($urandom_range(0, 7));
                be[n] = 4'($urandom);
                wd[n] = $urandom;
                rq[n] = rd[n] || wr[n];
            end
            set_m0(rd[0], wr[0], lk[0], ad[0], be[0], wd[0]);
            set_m1(rd[1], wr[1], lk[1], ad[1], be[1], wd[1]);

            // Who should get the RAM this cycle
            if (!rq[0] && !rq[1])      g = -1;
            else if (rq[0] && !rq[1])  g = 0;
            else if (rq[1] && !rq[0])  g = 1;
            else if (mdl_owner >= 0 && lk[mdl_owner] && mdl_streak < MAX_HOLD) g = mdl_owner;
            else                       g = 1 - mdl_last;

            @(negedge clk);
            check($sformatf("rnd%0d_wait0", c), bus.m0_waitrequest, (rq[0] && g != 0) ? 1 : 0);
            check($sformatf("rnd%0d_wait1", c), bus.m1_waitrequest, (rq[1] && g != 1) ? 1 : 0);
            check($sformatf("rnd%0d_cs", c),    bus.mem_chipselect, (g >= 0) ? 1 : 0);
            check($sformatf("rnd%0d_mw", c),    bus.mem_write, (g >= 0 && wr[g]) ? 1 : 0);
            check($sformatf("rnd%0d_clken", c), bus.mem_clken, 1);
            check($sformatf("rnd%0d_rdv0", c),  bus.m0_readdatavalid, (mdl_pend && mdl_pend_id == 0) ? 1 : 0);
            check($sformatf("rnd%0d_rdv1", c),  bus.m1_readdatavalid, (mdl_pend && mdl_pend_id == 1) ? 1 : 0);
            if (mdl_pend)
                check($sformatf("rnd%0d_rdata", c),
                      (mdl_pend_id == 0) ? bus.m0_readdata : bus.m1_readdata, mdl_pend_data);
            if (g >= 0) begin
                check($sformatf("rnd%0d_addr", c), bus.mem_address, ad[g]);
                check($sformatf("rnd%0d_be", c),   bus.mem_byteenable, be[g]);
                if (wr[g])
                    check($sformatf("rnd%0d_wd", c), bus.mem_writedata, wd[g]);
            end

            // Advance the model by one cycle
            mdl_pend = (g >= 0) && !wr[g];
            if (mdl_pend) begin
                mdl_pend_id   = g;
                mdl_pend_data = shadow[ad[g]];
            end
            if (g >= 0 && wr[g]) begin
                for (int b = 0; b < 4; b++)
                    if (be[g][b]) shadow[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
            end
            if (g < 0)                 mdl_streak = 0;
            else if (g == mdl_owner)   mdl_streak = (mdl_streak < MAX_HOLD) ? mdl_streak + 1 : MAX_HOLD;
            else                       mdl_streak = 1;
            mdl_owner = g;
            if (g >= 0) mdl_last = g;

            step();
        end

        idle_all();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
